// File: rtl/output_port_arbiter.sv
// Per-output switch arbiter: round-robin HEAD/SINGLE selection, wormhole lock, VC credits.
// Optional sticky protocol_err output when OPA_PROTOCOL_CHECK_EN is defined.
module output_port_arbiter #(
    parameter int NUM_IN    = 5,
    parameter int NUM_VC    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    input  logic [3*NUM_IN-1:0]   req_flit_type,
    input  logic [2*NUM_IN-1:0]   req_vc,
    input  logic [NUM_VC-1:0]     credit_in,
    output logic [NUM_IN-1:0]     grant,
    output logic [2:0]            out_select,
    output logic [1:0]            out_vc,
    output logic                  fire,
    output logic                  locked,
    output logic [2:0]            owner,
    output logic [3*NUM_VC-1:0]   credit_count
`ifdef OPA_PROTOCOL_CHECK_EN
    ,
    output logic                  protocol_err
`endif
);

    localparam logic [2:0] FT_HEAD   = 3'b001;
    localparam logic [2:0] FT_BODY   = 3'b010;
    localparam logic [2:0] FT_TAIL   = 3'b011;
    localparam logic [2:0] FT_SINGLE = 3'b100;
    localparam logic [2:0] CNT_FULL  = 3'(BUF_DEPTH);
    localparam logic [2:0] NO_OWNER  = 3'b111;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  owner_q, owner_d;
    logic [1:0]  lvc_q, lvc_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  cred_q [NUM_VC];
    logic [2:0]  cred_d [NUM_VC];

    logic [2:0]  typ [NUM_IN];
    logic [1:0]  vc [NUM_IN];
    logic [NUM_IN-1:0] has_cred;
    logic [NUM_IN-1:0] vc_bad;
    logic [NUM_IN-1:0] elig;
    logic [NUM_VC-1:0] cred_nz;
    logic        lk_cred;
    logic        win_found;
    logic [2:0]  win_idx;
    logic        own_go;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            typ[i] = req_flit_type[3*i +: 3];
            vc[i]  = req_vc[2*i +: 2];
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            cred_nz[v] = (cred_q[v] != 3'd0);
        end
    end

    // A VC index outside the configured range matches no counter, so it never has credit
    always_comb begin
        lk_cred = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (lvc_q == 2'(v)) lk_cred = cred_nz[v];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            has_cred[i] = 1'b0;
            vc_bad[i]   = (int'(vc[i]) >= NUM_VC);
            for (int v = 0; v < NUM_VC; v++) begin
                if (vc[i] == 2'(v)) has_cred[i] = cred_nz[v];
            end
            elig[i] = req[i] && has_cred[i] &&
                      (typ[i] == FT_HEAD || typ[i] == FT_SINGLE);
        end
    end

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(ptr_q) + k) % NUM_IN;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
            end
        end
    end

    always_comb begin
        own_go = 1'b0;
        if (state_q == LOCKED) begin
            own_go = req[owner_q] && lk_cred &&
                     (typ[owner_q] == FT_BODY || typ[owner_q] == FT_TAIL);
        end
    end

    always_comb begin
        grant      = '0;
        out_select = NO_OWNER;
        out_vc     = 2'd0;
        state_d    = state_q;
        owner_d    = owner_q;
        lvc_d      = lvc_q;
        ptr_d      = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant[win_idx] = 1'b1;
                    out_select     = win_idx;
                    out_vc         = vc[win_idx];
                    ptr_d          = 3'((int'(win_idx) + 1) % NUM_IN);
                    if (typ[win_idx] == FT_HEAD) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                        lvc_d   = vc[win_idx];
                    end
                end
            end
            LOCKED: begin
                if (own_go) begin
                    grant[owner_q] = 1'b1;
                    out_select     = owner_q;
                    out_vc         = lvc_q;
                    if (typ[owner_q] == FT_TAIL) begin
                        state_d = IDLE;
                        owner_d = NO_OWNER;
                    end
                end
            end
            default: ;
        endcase
    end

    assign fire = |grant;

    // Returns arriving at a full counter are dropped rather than wrapping
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            cred_d[v] = cred_q[v];
            if (fire && out_vc == 2'(v)) begin
                if (!credit_in[v]) cred_d[v] = cred_q[v] - 3'd1;
            end else if (credit_in[v] && cred_q[v] != CNT_FULL) begin
                cred_d[v] = cred_q[v] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= NO_OWNER;
            lvc_q   <= 2'd0;
            ptr_q   <= 3'd0;
            for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CNT_FULL;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lvc_q   <= lvc_d;
            ptr_q   <= ptr_d;
            for (int v = 0; v < NUM_VC; v++) cred_q[v] <= cred_d[v];
        end
    end

    assign locked = (state_q == LOCKED);
    assign owner  = owner_q;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            credit_count[3*v +: 3] = cred_q[v];
        end
    end

`ifdef OPA_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (req[i] && vc_bad[i]) err_d = 1'b1;
            if (req[i] && state_q == IDLE &&
                (typ[i] == FT_BODY || typ[i] == FT_TAIL)) err_d = 1'b1;
        end
        if (state_q == LOCKED && req[owner_q] &&
            (typ[owner_q] == FT_HEAD || typ[owner_q] == FT_SINGLE)) err_d = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (credit_in[v] && cred_q[v] == CNT_FULL &&
                !(fire && out_vc == 2'(v))) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign protocol_err = err_q;
`else
    logic unused_ok;
    assign unused_ok = ^vc_bad;
`endif

endmodule
